// File: rtl/alu_mc.sv
// alu_mc: multicycle integer ALU for the execute stage.
// ADD/SUB/AND/OR/SLT/NOP and divide-by-zero finish in one edge. MUL
// (shift-add) and DIV (restoring, unsigned) take WIDTH edges. Results stay
// registered until the next completion.
//
// Handshake: START is a request and is sampled only on an edge where BUSY=0.
// While BUSY=1, START and the operand inputs are ignored (no queueing).
// DONE is a one-cycle pulse that marks the cycle in which R/REM/Z_flag/DIVZ
// carry a new result. BUSY=0 in a DONE cycle, so a START presented in that
// cycle is accepted and operations can run back to back.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic [2:0]       SEL,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] REM,
  output logic             Z_flag,
  output logic             DIVZ
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_NOP = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t state, state_nxt;

  // Iteration registers. opa holds the multiplicand (MUL) or divisor (DIV);
  // opb holds the multiplier (MUL) or the dividend that is shifted out while
  // quotient bits are shifted in (DIV).
  logic [CW-1:0]    cnt;
  logic             op_is_mul;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   rem_acc;

  // Control decoded from state and request
  logic load_single;
  logic load_divz;
  logic start_iter;
  logic iter_last;

  // Combinational results
  logic [WIDTH-1:0] single_r;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH:0]   div_rem_nxt;
  logic [WIDTH-1:0] div_quot_nxt;
  logic [WIDTH-1:0] fin_r;
  logic [WIDTH-1:0] fin_rem;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control decode; divide by zero never enters ITER
  always_comb begin
    state_nxt   = state;
    BUSY        = 1'b0;
    load_single = 1'b0;
    load_divz   = 1'b0;
    start_iter  = 1'b0;
    iter_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          if (SEL == OP_MUL || (SEL == OP_DIV && Y != '0)) begin
            start_iter = 1'b1;
            state_nxt  = S_ITER;
          end else if (SEL == OP_DIV) begin
            load_divz = 1'b1;
          end else begin
            load_single = 1'b1;
          end
        end
      end
      S_ITER: begin
        BUSY = 1'b1;
        if (cnt == CNT_ONE) begin
          iter_last = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle operations straight from the operand inputs
  always_comb begin
    single_r = '0;
    case (SEL)
      OP_ADD:  single_r = X + Y;
      OP_SUB:  single_r = X - Y;
      OP_AND:  single_r = X & Y;
      OP_OR:   single_r = X | Y;
      OP_SLT:  single_r = {{(WIDTH-1){1'b0}}, (X < Y)};
      OP_NOP:  single_r = X;
      default: single_r = '0;
    endcase
  end

  // One MUL / DIV step, plus the values loaded on the final step
  always_comb begin
    mul_acc_nxt  = opb[0] ? (acc + opa) : acc;
    div_shift    = (rem_acc << 1) | {{WIDTH{1'b0}}, opb[WIDTH-1]};
    div_ge       = (div_shift >= {1'b0, opa});
    div_rem_nxt  = div_ge ? (div_shift - {1'b0, opa}) : div_shift;
    div_quot_nxt = {opb[WIDTH-2:0], div_ge};
    fin_r        = op_is_mul ? mul_acc_nxt : div_quot_nxt;
    fin_rem      = op_is_mul ? '0 : WIDTH'(div_rem_nxt);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DONE      <= 1'b0;
      R         <= '0;
      REM       <= '0;
      Z_flag    <= 1'b1;
      DIVZ      <= 1'b0;
      cnt       <= '0;
      op_is_mul <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      rem_acc   <= '0;
    end else begin
      DONE <= load_single | load_divz | iter_last;
      if (load_single) begin
        R      <= single_r;
        REM    <= '0;
        Z_flag <= (single_r == '0);
        DIVZ   <= 1'b0;
      end
      if (load_divz) begin
        R      <= '1;
        REM    <= X;
        Z_flag <= 1'b0;
        DIVZ   <= 1'b1;
      end
      if (start_iter) begin
        op_is_mul <= (SEL == OP_MUL);
        cnt       <= CNT_INIT;
        acc       <= '0;
        rem_acc   <= '0;
        opa       <= (SEL == OP_MUL) ? X : Y;
        opb       <= (SEL == OP_MUL) ? Y : X;
      end
      if (BUSY) begin
        cnt <= cnt - CNT_ONE;
        if (op_is_mul) begin
          acc <= mul_acc_nxt;
          opa <= opa << 1;
          opb <= opb >> 1;
        end else begin
          rem_acc <= div_rem_nxt;
          opb     <= div_quot_nxt;
        end
      end
      if (iter_last) begin
        R      <= fin_r;
        REM    <= fin_rem;
        Z_flag <= (fin_r == '0);
        DIVZ   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit and an 8-bit instance, directed cases plus
// random traffic, expectations from an arithmetic reference model.
module tb_alu_mc;

  localparam int W0 = 32;
  localparam int W1 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          start0, start1;
  logic [2:0]    sel0, sel1;
  logic [W0-1:0] x0, y0, r0, rem0;
  logic [W1-1:0] x1, y1, r1, rem1;
  logic          busy0, done0, z0, divz0;
  logic          busy1, done1, z1, divz1;

  alu_mc #(.WIDTH(W0)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .START(start0), .SEL(sel0), .X(x0), .Y(y0),
    .BUSY(busy0), .DONE(done0), .R(r0), .REM(rem0), .Z_flag(z0), .DIVZ(divz0)
  );

  alu_mc #(.WIDTH(W1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .START(start1), .SEL(sel1), .X(x1), .Y(y1),
    .BUSY(busy1), .DONE(done1), .R(r1), .REM(rem1), .Z_flag(z1), .DIVZ(divz1)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [63:0] r;
    logic [63:0] rem;
    logic        z;
    logic        divz;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference model: results straight from the arithmetic definitions.
  // Completion is expected at the sampling point 1 cycle after issue for
  // single-edge ops, WIDTH cycles later than that for MUL/DIV.
  function automatic exp_t model(input int w, input logic [2:0] sel,
                                 input logic [63:0] xi, input logic [63:0] yi,
                                 input int unsigned issue_cyc);
    exp_t e;
    logic [63:0] mask, x, y;
    bit iter;
    mask = (64'd1 << w) - 64'd1;
    x = xi & mask;
    y = yi & mask;
    e = '0;
    iter = 1'b0;
    case (sel)
      3'd0: e.r = (x + y) & mask;
      3'd1: e.r = (x - y) & mask;
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = (x < y) ? 64'd1 : 64'd0;
      3'd5: e.r = x;
      3'd6: begin e.r = (x * y) & mask; iter = 1'b1; end
      default: begin
        if (y == 0) begin
          e.r = mask; e.rem = x; e.divz = 1'b1;
        end else begin
          e.r = x / y; e.rem = x % y; iter = 1'b1;
        end
      end
    endcase
    e.z = (e.r == 0);
    e.cyc = issue_cyc + 1 + (iter ? w : 0);
    return e;
  endfunction

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done0) begin
      if (exp_q0.size() == 0) begin
        check("w32_unexpected_done", done0, 1'b0);
      end else begin
        e = exp_q0.pop_front();
        check("w32_R", r0, e.r);
        check("w32_REM", rem0, e.rem);
        check("w32_Z_flag", z0, e.z);
        check("w32_DIVZ", divz0, e.divz);
        check("w32_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done1) begin
      if (exp_q1.size() == 0) begin
        check("w8_unexpected_done", done1, 1'b0);
      end else begin
        e = exp_q1.pop_front();
        check("w8_R", r1, e.r);
        check("w8_REM", rem1, e.rem);
        check("w8_Z_flag", z1, e.z);
        check("w8_DIVZ", divz1, e.divz);
        check("w8_done_cycle", cyc, e.cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one request on the next falling edge and records its expectation.
  task automatic drive(input bit inst, input logic [2:0] sel,
                       input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    if (!inst) begin
      start0 = 1'b1; sel0 = sel; x0 = x[W0-1:0]; y0 = y[W0-1:0];
      exp_q0.push_back(model(W0, sel, x, y, cyc));
    end else begin
      start1 = 1'b1; sel1 = sel; x1 = x[W1-1:0]; y1 = y[W1-1:0];
      exp_q1.push_back(model(W1, sel, x, y, cyc));
    end
  endtask

  // Drops START and waits for all outstanding results, counting BUSY cycles.
  task automatic wait_done(input bit inst, input int budget, output int busy_n);
    int n;
    int left;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    busy_n = 0;
    n = 0;
    left = inst ? exp_q1.size() : exp_q0.size();
    while (left > 0 && n < budget) begin
      if (inst ? busy1 : busy0) busy_n++;
      @(negedge clk);
      n++;
      left = inst ? exp_q1.size() : exp_q0.size();
    end
    if (left > 0) begin
      check(inst ? "w8_timeout_pending" : "w32_timeout_pending", left, 0);
      if (inst) exp_q1.delete(); else exp_q0.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int busy_n;
    int unsigned t;
    logic [2:0] s;
    logic [63:0] a, b;

    rst_n = 1'b0;
    start0 = 1'b0; sel0 = '0; x0 = '0; y0 = '0;
    start1 = 1'b0; sel1 = '0; x1 = '0; y1 = '0;
    repeat (2) @(negedge clk);
    check("rst_BUSY", busy0, 1'b0);
    check("rst_DONE", done0, 1'b0);
    check("rst_R", r0, 0);
    check("rst_REM", rem0, 0);
    check("rst_Z_flag", z0, 1'b1);
    check("rst_DIVZ", divz0, 1'b0);
    check("rst_w8_Z_flag", z1, 1'b1);
    rst_n = 1'b1;

    // Reset in the middle of a MUL: aborted, no DONE ever appears
    @(negedge clk);
    start0 = 1'b1; sel0 = 3'd6; x0 = 32'h0001_0001; y0 = 32'h0000_0003;
    t = cyc;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    check("abort_BUSY_before_reset", busy0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_BUSY", busy0, 1'b0);
    check("abort_DONE", done0, 1'b0);
    check("abort_R", r0, 0);
    check("abort_Z_flag", z0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    drive(0, 3'd0, 5, 7);
    wait_done(0, 10, busy_n);

    // Back-to-back single-cycle ops: consecutive DONE pulses
    drive(0, 3'd1, 3, 3);
    drive(0, 3'd4, 2, 9);
    drive(0, 3'd5, 64'hDEAD_BEEF, 1);
    wait_done(0, 10, busy_n);
    check("single_busy_cycles", busy_n, 0);

    // MUL
    drive(0, 3'd6, 64'h0001_0001, 64'h0001_0001);
    wait_done(0, 60, busy_n);
    check("mul_busy_cycles", busy_n, W0);
    drive(0, 3'd6, 64'hFFFF_FFFF, 2);
    wait_done(0, 60, busy_n);

    // DIV
    drive(0, 3'd7, 100, 7);
    wait_done(0, 60, busy_n);
    check("div_busy_cycles", busy_n, W0);
    drive(0, 3'd7, 5, 9);
    wait_done(0, 60, busy_n);

    // Divide by zero, then ADD clears DIVZ
    drive(0, 3'd7, 42, 0);
    drive(0, 3'd0, 1, 2);
    wait_done(0, 10, busy_n);
    check("divz_busy_cycles", busy_n, 0);

    // Busy interlock: a START with new operands mid-MUL is ignored
    drive(0, 3'd6, 64'h0000_1234, 64'h0000_0055);
    t = cyc;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < t + 5) @(negedge clk);
    start0 = 1'b1; sel0 = 3'd0; x0 = $urandom; y0 = $urandom;
    @(negedge clk);
    start0 = 1'b0; x0 = $urandom; y0 = $urandom;
    wait_done(0, 60, busy_n);

    // New START in the DONE cycle of a MUL is accepted
    drive(0, 3'd6, 64'h0000_0007, 64'h0000_0009);
    t = cyc;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < t + W0) @(negedge clk);
    drive(0, 3'd1, 10, 20);
    wait_done(0, 10, busy_n);

    // 8-bit instance
    drive(1, 3'd7, 200, 3);
    wait_done(1, 30, busy_n);
    check("w8_div_busy_cycles", busy_n, W1);

    // Random traffic on both widths
    for (int k = 0; k < 40; k++) begin
      s = 3'($urandom_range(0, 7));
      a = {32'd0, $urandom};
      b = ($urandom_range(0, 5) == 0) ? 64'd0 : {32'd0, $urandom};
      drive(0, s, a, b);
      if (s >= 3'd6 || $urandom_range(0, 3) == 0) wait_done(0, 60, busy_n);
    end
    wait_done(0, 60, busy_n);
    for (int k = 0; k < 40; k++) begin
      s = 3'($urandom_range(0, 7));
      a = 64'($urandom_range(0, 255));
      b = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      drive(1, s, a, b);
      if (s >= 3'd6 || $urandom_range(0, 3) == 0) wait_done(1, 30, busy_n);
    end
    wait_done(1, 30, busy_n);

    repeat (5) @(negedge clk);
    check("queues_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multicycle successor to the single-cycle integer ALU in the execute stage.
- Keeps the same 3-bit operation encoding; generalises the data width.
- Replaces the combinational `*` and `/` with iterative shift-add multiply and restoring divide, fronted by a START/BUSY/DONE handshake.
- Registers the result, zero flag, remainder and divide-by-zero flag until the next completion, so the control unit can stall on BUSY.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CW, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- START  in  1  request; sampled only when BUSY=0.
- SEL  in  3  op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (unsigned), 5 NOP (pass X), 6 MUL, 7 DIV (unsigned).
- X  in  WIDTH  operand A / dividend / multiplicand.
- Y  in  WIDTH  operand B / divisor / multiplier.
- BUSY  out  1  iteration in progress.
- DONE  out  1  one-cycle pulse: R/Z_flag/REM/DIVZ updated this cycle.
- R  out  WIDTH  result (MUL: low WIDTH bits of product; DIV: quotient).
- REM  out  WIDTH  DIV remainder; 0 after any other op.
- Z_flag  out  1  1 when the R just loaded == 0.
- DIVZ  out  1  1 when the last DIV had Y==0; 0 after any other op.

Behaviour:
- Reset (async, rst_n low): state IDLE, BUSY=0, DONE=0, R=0, REM=0, Z_flag=1, DIVZ=0, counter=0, internal operand regs=0. Asserting reset mid-iteration aborts the op; no DONE is produced.
- States:
  - IDLE: not busy. START=1 at edge k:
    - SEL 0–5: compute combinationally from X/Y, load R/REM/Z_flag/DIVZ at edge k. DONE=1 for the cycle after edge k. Stay in IDLE. Latency 1.
    - SEL 6/7: capture X, Y, SEL into internal regs, counter=WIDTH, go ITER, BUSY=1 after edge k.
  - ITER: one iteration per edge; counter decrements.
    - MUL: if multiplier LSB=1, acc += multiplicand; shift multiplicand left and multiplier right; acc is WIDTH bits (overflow discarded).
    - DIV: restoring. Shift {rem,quot} left 1; if rem ≥ divisor, subtract and set quot LSB. Rem register is WIDTH+1 bits internally.
    - On the edge where counter reaches 0 (edge k+WIDTH): load R/REM/Z_flag/DIVZ, go IDLE, BUSY=0, DONE=1 for the following cycle. Latency WIDTH edges.
- Divide by zero: no iteration. At edge k, R=all ones, REM=X, DIVZ=1, Z_flag=0, DONE next cycle, stay IDLE (latency 1).
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
  - SLT yields R={WIDTH-1 zeros, X<Y} (unsigned).
  - NOP yields R=X.
- Operand inputs are ignored while BUSY=1.
- START while BUSY=1 is ignored: not queued, no error.
- DONE and a new START in the same cycle: the new START is accepted (back-to-back ops allowed).
- Outputs hold their last value between DONE pulses. DONE is never high for two consecutive cycles from one op; back-to-back single-cycle ops do give consecutive DONEs.
- SEL values are all defined; there are no X outputs.

Test Plan:
- Reset/idle, WIDTH=32: rst_n low mid-MUL at cycle 10 → BUSY=0, DONE never asserts, R=0, Z_flag=1; after release, ADD X=5 Y=7 → DONE 1 cycle later, R=12, Z_flag=0.
- Single-cycle ops back-to-back: SUB 3−3 then SLT 2<9 then NOP X=0xDEADBEEF on consecutive cycles → DONE high 3 consecutive cycles; R=0 (Z_flag=1), then 1, then 0xDEADBEEF.
- MUL:
  - X=0x0001_0001, Y=0x0001_0001 → BUSY 32 cycles, DONE exactly 32 edges after START, R=0x0002_0001.
  - X=0xFFFF_FFFF, Y=2 → R=0xFFFF_FFFE.
- DIV:
  - X=100, Y=7 → R=14, REM=2, DIVZ=0, latency 32.
  - X=5, Y=9 → R=0, REM=5, Z_flag=1.
- Divide by zero: X=42, Y=0, SEL=7 → DONE after 1 cycle, R=0xFFFF_FFFF, REM=42, DIVZ=1; following ADD clears DIVZ to 0.
- Busy interlock: START MUL, then pulse START with SEL=0 and change X/Y at cycle 5 → ignored; MUL result uses the captured operands; only one DONE, at edge 32. Rerun with WIDTH=8: X=200, Y=3 DIV → R=66, REM=2, latency 8.
